frame_buffer: RTL and testbench

FRAME_BUFFER -- requirements
Module: frame_buffer

---
 rtl/frame_buffer.sv | 147 ++++++++++++++
 tb/tb_frame_buffer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer.sv
// Double-buffered colour frame store: the back bank is cleared and rendered into
// while the front bank is scanned out, with the banks swapped on vertical blank.
module frame_buffer #(
  parameter int BUFFER_WIDTH = 160,
  parameter int BUFFER_HEIGHT = 120,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int COLOR_WIDTH = 12,
  parameter int PIXEL_WIDTH = COLOR_WIDTH,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         write_en_in,
  input  logic [BUFFER_ADDR_WIDTH-1:0] write_addr_in,
  input  logic [PIXEL_WIDTH-1:0]       write_pixel_in,
  input  logic                         frame_start,
  input  logic                         render_done,
  input  logic                         vsync,
  input  logic [BUFFER_ADDR_WIDTH-1:0] display_addr,
  output logic [COLOR_WIDTH-1:0]       display_data,
  output logic                         clear_req,
  output logic [BUFFER_ADDR_WIDTH-1:0] clear_addr,
  output logic                         ready,
  output logic                         front_sel,
  output logic                         frame_swapped,
  output logic                         write_dropped
);

  localparam int N = BUFFER_WIDTH * BUFFER_HEIGHT;
  localparam logic [BUFFER_ADDR_WIDTH:0] N_EXT = (BUFFER_ADDR_WIDTH + 1)'(N);
  localparam logic [BUFFER_ADDR_WIDTH:0] LAST_EXT = N_EXT - 1'b1;

  typedef enum logic [1:0] {IDLE, CLEAR, RENDER, WAIT_VSYNC} state_t;

  state_t                       state_reg, state_next;
  logic                         clear_req_reg, clear_req_next;
  logic [BUFFER_ADDR_WIDTH-1:0] clear_addr_reg, clear_addr_next;
  logic                         ready_reg, ready_next;
  logic                         front_sel_reg, front_sel_next;
  logic                         frame_swapped_reg, frame_swapped_next;
  logic                         write_dropped_reg, write_dropped_next;
  logic                         disp_valid_reg, disp_sel_reg;

  logic                         wr_accept, clearing, clear_last, back_sel, bank_we;
  logic [BUFFER_ADDR_WIDTH-1:0] bank_waddr;
  logic [COLOR_WIDTH-1:0]       bank_wdata;
  logic [COLOR_WIDTH-1:0]       bank_rd [2];

  function automatic logic in_range(input logic [BUFFER_ADDR_WIDTH-1:0] a);
    return {1'b0, a} < N_EXT;
  endfunction

  assign clearing   = (state_reg == CLEAR);
  assign clear_last = ({1'b0, clear_addr_reg} == LAST_EXT);
  assign wr_accept  = (state_reg == RENDER) && write_en_in && in_range(write_addr_in);
  assign back_sel   = ~front_sel_reg;

  // Clear sweep and pixel writes never overlap, so one write port per bank suffices.
  assign bank_we    = clearing || wr_accept;
  assign bank_waddr = clearing ? clear_addr_reg : write_addr_in;
  assign bank_wdata = clearing ? CLEAR_COLOR : write_pixel_in[COLOR_WIDTH-1:0];

  always_comb begin
    state_next         = state_reg;
    clear_req_next     = 1'b0;
    clear_addr_next    = clear_addr_reg;
    front_sel_next     = front_sel_reg;
    frame_swapped_next = 1'b0;
    write_dropped_next = write_en_in && !wr_accept;
    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next      = CLEAR;
          clear_req_next  = 1'b1;
          clear_addr_next = '0;
        end
      end
      CLEAR: begin
        if (clear_last) begin
          state_next = RENDER;
        end else begin
          clear_req_next  = 1'b1;
          clear_addr_next = clear_addr_reg + BUFFER_ADDR_WIDTH'(1);
        end
      end
      RENDER: begin
        if (render_done) state_next = WAIT_VSYNC;
      end
      WAIT_VSYNC: begin
        if (vsync) begin
          state_next         = IDLE;
          front_sel_next     = ~front_sel_reg;
          frame_swapped_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == RENDER);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg         <= IDLE;
      clear_req_reg     <= 1'b0;
      clear_addr_reg    <= '0;
      ready_reg         <= 1'b0;
      front_sel_reg     <= 1'b0;
      frame_swapped_reg <= 1'b0;
      write_dropped_reg <= 1'b0;
      disp_valid_reg    <= 1'b0;
      disp_sel_reg      <= 1'b0;
    end else begin
      state_reg         <= state_next;
      clear_req_reg     <= clear_req_next;
      clear_addr_reg    <= clear_addr_next;
      ready_reg         <= ready_next;
      front_sel_reg     <= front_sel_next;
      frame_swapped_reg <= frame_swapped_next;
      write_dropped_reg <= write_dropped_next;
      disp_valid_reg    <= in_range(display_addr);
      disp_sel_reg      <= front_sel_reg;
    end
  end

  // RAM read registers carry no reset; the valid flag forces display_data to 0.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [COLOR_WIDTH-1:0] mem [0:N-1];
      logic [COLOR_WIDTH-1:0] rd_reg;
      always_ff @(posedge clk) begin
        if (bank_we && (back_sel == 1'(gi))) mem[bank_waddr] <= bank_wdata;
        rd_reg <= mem[display_addr];
      end
      assign bank_rd[gi] = rd_reg;
    end
  endgenerate

  assign display_data  = disp_valid_reg ? bank_rd[disp_sel_reg] : '0;
  assign clear_req     = clear_req_reg;
  assign clear_addr    = clear_addr_reg;
  assign ready         = ready_reg;
  assign front_sel     = front_sel_reg;
  assign frame_swapped = frame_swapped_reg;
  assign write_dropped = write_dropped_reg;

endmodule

// File: tb/tb_frame_buffer.sv
// Self-checking bench for frame_buffer: directed frame sequence with randomized
// pixel writes and scan-out reads checked against a two-bank memory model.
module tb_frame_buffer;
  localparam int N = 19200;
  localparam int AW = 15;
  localparam logic [11:0] CLR = 12'h000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          write_en_in;
  logic [AW-1:0] write_addr_in;
  logic [11:0]   write_pixel_in;
  logic          frame_start, render_done, vsync;
  logic [AW-1:0] display_addr;
  logic [11:0]   display_data;
  logic          clear_req;
  logic [AW-1:0] clear_addr;
  logic          ready, front_sel, frame_swapped, write_dropped;

  frame_buffer dut (
    .clk(clk), .rstn(rstn),
    .write_en_in(write_en_in), .write_addr_in(write_addr_in), .write_pixel_in(write_pixel_in),
    .frame_start(frame_start), .render_done(render_done), .vsync(vsync),
    .display_addr(display_addr), .display_data(display_data),
    .clear_req(clear_req), .clear_addr(clear_addr), .ready(ready),
    .front_sel(front_sel), .frame_swapped(frame_swapped), .write_dropped(write_dropped)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents of both banks, which entries are defined, which bank is shown.
  logic [11:0] mdl [2][N];
  bit          mknown [2][N];
  bit          m_front = 1'b0;
  bit          in_render = 1'b0;
  int          fixed_disp = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with an optional write; checks the drop pulse and the scan-out read.
  task automatic step(input bit wen, input int waddr, input logic [11:0] wcol);
    bit          exp_drop;
    bit          dk;
    logic [11:0] dexp;
    int          da;
    int          fb;
    int          bb;
    fb = m_front ? 1 : 0;
    bb = m_front ? 0 : 1;
    if (fixed_disp >= 0) da = fixed_disp;
    else if ($urandom_range(0, 15) == 0) da = int'($urandom_range(N, 32767));
    else da = int'($urandom_range(0, N - 1));
    display_addr   = AW'(da);
    write_en_in    = wen;
    write_addr_in  = AW'(waddr);
    write_pixel_in = wcol;
    exp_drop = wen && (!in_render || waddr >= N);
    if (da >= N) begin
      dk = 1'b1;
      dexp = 12'h000;
    end else begin
      dk = mknown[fb][da];
      dexp = mdl[fb][da];
    end
    @(posedge clk); #1;
    if (wen && !exp_drop) begin
      mdl[bb][waddr] = wcol;
      mknown[bb][waddr] = 1'b1;
    end
    write_en_in = 1'b0;
    check("write_dropped", write_dropped, exp_drop);
    if (dk) check("display_data", display_data, dexp);
  endtask

  task automatic run_clear(input int drop_at);
    int cnt = 0;
    int bb;
    bb = m_front ? 0 : 1;
    frame_start = 1'b1;
    step(1'b0, 0, 12'h000);
    frame_start = 1'b0;
    while (clear_req === 1'b1 && cnt < N + 10) begin
      check("clear_addr", clear_addr, cnt);
      if (cnt == drop_at) step(1'b1, 3, 12'h5A5);
      else step(1'b0, 0, 12'h000);
      cnt++;
    end
    check("clear_len", cnt, N);
    check("ready_after_clear", ready, 1);
    for (int a = 0; a < N; a++) begin
      mdl[bb][a] = CLR;
      mknown[bb][a] = 1'b1;
    end
    in_render = 1'b1;
  endtask

  task automatic random_render(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) step(1'b1, int'($urandom_range(1, N - 1)), 12'($urandom));
      else if (r == 5) step(1'b1, int'($urandom_range(N, 32767)), 12'($urandom));
      else step(1'b0, 0, 12'h000);
    end
  endtask

  initial begin
    rstn = 1'b0;
    write_en_in = 1'b0; write_addr_in = '0; write_pixel_in = '0;
    frame_start = 1'b0; render_done = 1'b0; vsync = 1'b0; display_addr = '0;

    // Reset state
    #12;
    check("rst_clear_req", clear_req, 0);
    check("rst_clear_addr", clear_addr, 0);
    check("rst_ready", ready, 0);
    check("rst_front_sel", front_sel, 0);
    check("rst_frame_swapped", frame_swapped, 0);
    check("rst_write_dropped", write_dropped, 0);
    check("rst_display_data", display_data, 0);
    #10 rstn = 1'b1;
    step(1'b0, 0, 12'h000);

    // Abort a clear sweep with reset after 100 cycles
    frame_start = 1'b1;
    step(1'b0, 0, 12'h000);
    frame_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      check("abort_clear_req", clear_req, 1);
      check("abort_clear_addr", clear_addr, i);
      step(1'b0, 0, 12'h000);
    end
    #2 rstn = 1'b0;
    #1;
    check("abort_req_drop", clear_req, 0);
    check("abort_addr_reset", clear_addr, 0);
    #3 rstn = 1'b1;
    m_front = 1'b0;
    in_render = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) step(1'b1, 11, 12'h123);
      else step(1'b0, 0, 12'h000);
      check("idle_clear_req", clear_req, 0);
    end

    // Frame 1: full clear with a dropped write at addr 3 mid-sweep
    run_clear(50);

    frame_start = 1'b1;
    step(1'b0, 0, 12'h000);
    frame_start = 1'b0;
    check("fs_in_render_ignored", clear_req, 0);
    vsync = 1'b1;
    step(1'b0, 0, 12'h000);
    vsync = 1'b0;
    check("vsync_in_render_ignored", frame_swapped, 0);
    random_render(300);
    step(1'b1, 5, 12'hABC);
    step(1'b1, N, 12'h777);
    render_done = 1'b1;
    step(1'b1, 7, 12'h3C7);
    render_done = 1'b0;
    in_render = 1'b0;
    check("wait_vsync_ready", ready, 0);
    step(1'b1, 9, 12'h999);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 12'h000);
    check("no_swap_before_vsync", front_sel, 0);

    // Swap, with a frame_start in the same cycle that must be ignored
    vsync = 1'b1;
    frame_start = 1'b1;
    step(1'b0, 0, 12'h000);
    vsync = 1'b0;
    frame_start = 1'b0;
    m_front = 1'b1;
    check("swap1_pulse", frame_swapped, 1);
    check("swap1_front_sel", front_sel, 1);
    step(1'b0, 0, 12'h000);
    check("swap1_pulse_end", frame_swapped, 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 12'h000);
      check("fs_with_vsync_ignored", clear_req, 0);
    end
    fixed_disp = 5;
    step(1'b0, 0, 12'h000);
    check("disp_addr5", display_data, 12'hABC);
    fixed_disp = 7;
    step(1'b0, 0, 12'h000);
    check("disp_addr7", display_data, 12'h3C7);
    fixed_disp = -1;

    // Frame 2: clear and render the other bank while bank 1 is scanned out
    run_clear(-1);
    random_render(300);
    render_done = 1'b1;
    step(1'b0, 0, 12'h000);
    render_done = 1'b0;
    in_render = 1'b0;
    vsync = 1'b1;
    step(1'b0, 0, 12'h000);
    vsync = 1'b0;
    m_front = 1'b0;
    check("swap2_pulse", frame_swapped, 1);
    check("swap2_front_sel", front_sel, 0);
    fixed_disp = 0;
    step(1'b0, 0, 12'h000);
    check("disp_addr0_clear", display_data, CLR);
    fixed_disp = N + 5;
    step(1'b0, 0, 12'h000);
    check("disp_out_of_range", display_data, 0);
    fixed_disp = -1;
    for (int i = 0; i < 50; i++) step(1'b0, 0, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
